// File: rtl/vend_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : vend_ctrl_fsm_if
//  Description : Bundle of the user events, datapath status and command/status
//                outputs of the vending control FSM. The audit counter signals
//                exist only when VEND_AUDIT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vend_ctrl_fsm_if;
    logic        in_coin;
    logic        in_sel;
    logic        in_buy;
    logic        in_cancel;
    logic        in_service;
    logic [15:0] in_change;
    logic        in_csel_any;
    logic [1:0]  out_cmd;
    logic [1:0]  out_state;
    logic        out_busy;
    logic        out_short;
    logic        out_refund;
`ifdef VEND_AUDIT_EN
    logic [15:0] out_vend_count;
    logic [15:0] out_refund_count;
`endif

    // Controller side: consumes events/status, drives command and status
    modport master (
        input  in_coin, in_sel, in_buy, in_cancel, in_service, in_change, in_csel_any,
`ifdef VEND_AUDIT_EN
        output out_vend_count, out_refund_count,
`endif
        output out_cmd, out_state, out_busy, out_short, out_refund
    );

    // Environment/datapath side
    modport slave (
        output in_coin, in_sel, in_buy, in_cancel, in_service, in_change, in_csel_any,
`ifdef VEND_AUDIT_EN
        input  out_vend_count, out_refund_count,
`endif
        input  out_cmd, out_state, out_busy, out_short, out_refund
    );
endinterface
`default_nettype wire

// File: rtl/vend_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : vend_ctrl_fsm
//  Description : Vending control FSM. Drives the 2-bit command bus into the
//                vending datapath through INIT (clear/restock), SELECT
//                (selection and coins, idle timeout), PAYOUT and DISPENSE.
//                Optional audit counters are enabled with VEND_AUDIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_ctrl_fsm #(
    parameter int TIMEOUT_CYC  = 1000,
    parameter int DISPENSE_CYC = 4,
    parameter int CNT_W        = 16
) (
    input  wire logic       in_clka,
    input  wire logic       in_restart,
    vend_ctrl_fsm_if.master bus
);
    localparam logic [1:0] c_ST_INIT     = 2'd0;
    localparam logic [1:0] c_ST_SELECT   = 2'd1;
    localparam logic [1:0] c_ST_PAYOUT   = 2'd2;
    localparam logic [1:0] c_ST_DISPENSE = 2'd3;

    localparam logic [1:0] c_CMD_SITEM  = 2'b00;
    localparam logic [1:0] c_CMD_SMONEY = 2'b01;
    localparam logic [1:0] c_CMD_CLEAR  = 2'b10;
    localparam logic [1:0] c_CMD_START  = 2'b11;

    localparam logic [CNT_W-1:0] c_TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] c_DSP_LAST = CNT_W'(DISPENSE_CYC - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_svc_pend;
    logic [1:0]       r_cmd;
    logic             r_busy;
    logic             r_short;
    logic             r_refund;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_svc_pend_nxt;
    logic             w_buy_rej;
    logic             w_pay_buy;
    logic             w_pay_refund;
    logic [1:0]       w_cmd_nxt;
    logic             w_busy_nxt;
    logic             w_short_nxt;
    logic             w_refund_nxt;

    wire logic w_activity = bus.in_coin | bus.in_sel | bus.in_buy | bus.in_cancel;
    wire logic w_credit   = (bus.in_change != 16'd0) | bus.in_csel_any;
    wire logic w_buy_ok   = bus.in_csel_any & ~bus.in_change[15];

    // State, counter and registered outputs; restart dominates everything
    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            r_state    <= c_ST_INIT;
            r_cnt      <= '0;
            r_svc_pend <= 1'b0;
            r_cmd      <= c_CMD_CLEAR;
            r_busy     <= 1'b0;
            r_short    <= 1'b0;
            r_refund   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_svc_pend <= w_svc_pend_nxt;
            r_cmd      <= w_cmd_nxt;
            r_busy     <= w_busy_nxt;
            r_short    <= w_short_nxt;
            r_refund   <= w_refund_nxt;
        end
    end

    // Next state, counter and payout cause; counter defaults to cleared
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = '0;
        w_svc_pend_nxt = 1'b0;
        w_buy_rej      = 1'b0;
        w_pay_buy      = 1'b0;
        w_pay_refund   = 1'b0;
        case (r_state)
            c_ST_INIT: begin
                if (!bus.in_service) w_state_nxt = c_ST_SELECT;
            end
            c_ST_SELECT: begin
                if (bus.in_service) begin
                    w_state_nxt = c_ST_INIT;
                end else if (bus.in_cancel) begin
                    w_state_nxt  = c_ST_PAYOUT;
                    w_pay_refund = 1'b1;
                end else if (bus.in_buy) begin
                    if (w_buy_ok) begin
                        w_state_nxt = c_ST_PAYOUT;
                        w_pay_buy   = 1'b1;
                    end else begin
                        w_buy_rej = 1'b1;
                    end
                end else if (!w_activity) begin
                    // Idle cycle: count, and at the last count either refund
                    // the credit or sit saturated until something happens
                    if (r_cnt == c_TO_LAST) begin
                        if (w_credit) begin
                            w_state_nxt  = c_ST_PAYOUT;
                            w_pay_refund = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            c_ST_PAYOUT: begin
                w_state_nxt = c_ST_DISPENSE;
            end
            c_ST_DISPENSE: begin
                // A service request seen at any point of the hold is honoured
                // when the hold ends
                if (r_cnt == c_DSP_LAST) begin
                    w_state_nxt = (r_svc_pend | bus.in_service) ? c_ST_INIT : c_ST_SELECT;
                end else begin
                    w_cnt_nxt      = r_cnt + 1'b1;
                    w_svc_pend_nxt = r_svc_pend | bus.in_service;
                end
            end
            default: begin
                w_state_nxt = c_ST_INIT;
            end
        endcase
    end

    // Output decode of the upcoming state, registered in the state process
    always_comb begin
        w_cmd_nxt = c_CMD_CLEAR;
        case (w_state_nxt)
            c_ST_INIT:     w_cmd_nxt = c_CMD_CLEAR;
            c_ST_SELECT:   w_cmd_nxt = c_CMD_START;
            c_ST_PAYOUT:   w_cmd_nxt = c_CMD_SMONEY;
            c_ST_DISPENSE: w_cmd_nxt = c_CMD_SITEM;
            default:       w_cmd_nxt = c_CMD_CLEAR;
        endcase
        w_busy_nxt   = (w_state_nxt == c_ST_PAYOUT) || (w_state_nxt == c_ST_DISPENSE);
        w_short_nxt  = w_buy_rej;
        w_refund_nxt = w_pay_refund;
    end

    assign bus.out_cmd    = r_cmd;
    assign bus.out_state  = r_state;
    assign bus.out_busy   = r_busy;
    assign bus.out_short  = r_short;
    assign bus.out_refund = r_refund;

`ifdef VEND_AUDIT_EN
    logic [15:0] r_vend_cnt;
    logic [15:0] r_refund_cnt;

    // Saturating purchase/refund tallies, cleared only by restart
    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            r_vend_cnt   <= 16'd0;
            r_refund_cnt <= 16'd0;
        end else begin
            if (w_pay_buy && (r_vend_cnt != 16'hFFFF))
                r_vend_cnt <= r_vend_cnt + 16'd1;
            if (w_pay_refund && (r_refund_cnt != 16'hFFFF))
                r_refund_cnt <= r_refund_cnt + 16'd1;
        end
    end

    assign bus.out_vend_count   = r_vend_cnt;
    assign bus.out_refund_count = r_refund_cnt;
`endif

endmodule
`default_nettype wire
